// File: rtl/uart_pkt_parser.sv
// Frames UART RX bytes into SYNC/LEN/PAYLOAD/CHK packets and replays good payloads on a valid/ready stream.
// Optional inter-byte timeout is built when UART_PKT_TIMEOUT_EN is defined.
module uart_pkt_parser #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 104160
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Data_Valid,
    output logic [7:0] o_Data_Byte,
    output logic       o_Data_Last,
    input  logic       i_Data_Ready,
    output logic       o_Pkt_Done,
    output logic       o_Err_Chk,
    output logic       o_Err_Len,
    output logic       o_Err_Timeout,
    output logic       o_Busy
);

    localparam int         IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CHK     = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t     state_q;
    logic [7:0] len_q;
    logic [7:0] chk_q;
    logic [7:0] idx_q;
    logic [7:0] rd_idx_q;
    logic [7:0] mem_q [MAX_LEN];

    logic [7:0] chk_d;
    logic       hs_s;
    logic       last_s;
    logic       timeout_s;

    assign chk_d  = chk_q ^ i_Rx_Byte;
    assign hs_s   = o_Data_Valid & i_Data_Ready;
    assign last_s = (rd_idx_q == (len_q - 8'd1));

    // Outputs are forced to zero outside DRAIN so the buffer's reset-free contents never leak out.
    assign o_Data_Byte = o_Data_Valid ? mem_q[rd_idx_q[IW-1:0]] : 8'h00;
    assign o_Data_Last = o_Data_Valid & last_s;

`ifdef UART_PKT_TIMEOUT_EN
    localparam int            TW      = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);

    logic [TW-1:0] to_cnt_q;

    // A byte arriving on the expiry clock wins over the timeout.
    assign timeout_s = (state_q inside {S_LEN, S_PAYLOAD, S_CHK}) && !i_Rx_DV && (to_cnt_q == TO_LAST);

    // Inter-byte counter: runs only while a packet is being received.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            to_cnt_q <= {TW{1'b0}};
        end else if (!(state_q inside {S_LEN, S_PAYLOAD, S_CHK}) || i_Rx_DV || timeout_s) begin
            to_cnt_q <= {TW{1'b0}};
        end else begin
            to_cnt_q <= to_cnt_q + {{(TW-1){1'b0}}, 1'b1};
        end
    end
`else
    assign timeout_s = 1'b0 & (TIMEOUT_CLKS > 0);
`endif

    // Payload buffer write port; contents need no reset.
    always_ff @(posedge i_Clock) begin
        if ((state_q == S_PAYLOAD) && i_Rx_DV) begin
            mem_q[idx_q[IW-1:0]] <= i_Rx_Byte;
        end
    end

    // Packet FSM with registered pulses, valid and busy.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state_q       <= S_IDLE;
            len_q         <= 8'd0;
            chk_q         <= 8'd0;
            idx_q         <= 8'd0;
            rd_idx_q      <= 8'd0;
            o_Data_Valid  <= 1'b0;
            o_Pkt_Done    <= 1'b0;
            o_Err_Chk     <= 1'b0;
            o_Err_Len     <= 1'b0;
            o_Err_Timeout <= 1'b0;
            o_Busy        <= 1'b0;
        end else begin
            o_Pkt_Done    <= 1'b0;
            o_Err_Chk     <= 1'b0;
            o_Err_Len     <= 1'b0;
            o_Err_Timeout <= 1'b0;
            if (timeout_s) begin
                o_Err_Timeout <= 1'b1;
                o_Busy        <= 1'b0;
                state_q       <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                            state_q <= S_LEN;
                            o_Busy  <= 1'b1;
                        end
                    end
                    S_LEN: begin
                        if (i_Rx_DV) begin
                            len_q <= i_Rx_Byte;
                            chk_q <= i_Rx_Byte;
                            idx_q <= 8'd0;
                            if (i_Rx_Byte > MAX_LEN_B) begin
                                o_Err_Len <= 1'b1;
                                o_Busy    <= 1'b0;
                                state_q   <= S_IDLE;
                            end else if (i_Rx_Byte == 8'd0) begin
                                state_q <= S_CHK;
                            end else begin
                                state_q <= S_PAYLOAD;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (i_Rx_DV) begin
                            chk_q <= chk_d;
                            idx_q <= idx_q + 8'd1;
                            if (idx_q == (len_q - 8'd1)) begin
                                state_q <= S_CHK;
                            end
                        end
                    end
                    S_CHK: begin
                        if (i_Rx_DV) begin
                            if (i_Rx_Byte == chk_q) begin
                                o_Pkt_Done <= 1'b1;
                                if (len_q != 8'd0) begin
                                    rd_idx_q     <= 8'd0;
                                    o_Data_Valid <= 1'b1;
                                    state_q      <= S_DRAIN;
                                end else begin
                                    o_Busy  <= 1'b0;
                                    state_q <= S_IDLE;
                                end
                            end else begin
                                o_Err_Chk <= 1'b1;
                                o_Busy    <= 1'b0;
                                state_q   <= S_IDLE;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (hs_s) begin
                            if (last_s) begin
                                o_Data_Valid <= 1'b0;
                                o_Busy       <= 1'b0;
                                state_q      <= S_IDLE;
                            end else begin
                                rd_idx_q <= rd_idx_q + 8'd1;
                            end
                        end
                    end
                    default: begin
                        o_Data_Valid <= 1'b0;
                        o_Busy       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Directed self-checking bench for uart_pkt_parser; inputs change on falling edges, outputs are sampled there too.
module tb_uart_pkt_parser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       data_valid;
    logic [7:0] data_byte;
    logic       data_last;
    logic       data_ready;
    logic       pkt_done;
    logic       err_chk;
    logic       err_len;
    logic       err_timeout;
    logic       busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    uart_pkt_parser #(
        .SYNC_BYTE   (8'hA5),
        .MAX_LEN     (16),
        .TIMEOUT_CLKS(100)
    ) dut (
        .i_Clock      (clk),
        .i_Rst_n      (rst_n),
        .i_Rx_DV      (rx_dv),
        .i_Rx_Byte    (rx_byte),
        .o_Data_Valid (data_valid),
        .o_Data_Byte  (data_byte),
        .o_Data_Last  (data_last),
        .i_Data_Ready (data_ready),
        .o_Pkt_Done   (pkt_done),
        .o_Err_Chk    (err_chk),
        .o_Err_Len    (err_len),
        .o_Err_Timeout(err_timeout),
        .o_Busy       (busy)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [14:0] outs();
        return {data_valid, data_byte, data_last, pkt_done, err_chk, err_len, err_timeout, busy};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rec_byte [4];
        logic       rec_last [4];
        int         rec_n;
        int         bad;
        int         to_at;

        rst_n      = 1'b0;
        rx_dv      = 1'b0;
        rx_byte    = 8'h00;
        data_ready = 1'b1;
        repeat (3) tick();
        check("reset_outputs", 32'(outs()), 32'h0);
        rst_n = 1'b1;
        tick();

        // Good 3-byte packet, consumer always ready.
        send_byte(8'hA5);
        check("t1_busy_after_sync", 32'(busy), 32'h1);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h03);
        check("t1_done", 32'(pkt_done), 32'h1);
        check("t1_b0", 32'({data_valid, data_byte, data_last}), 32'({1'b1, 8'h11, 1'b0}));
        tick();
        check("t1_done_one_clk", 32'(pkt_done), 32'h0);
        check("t1_b1", 32'({data_valid, data_byte, data_last}), 32'({1'b1, 8'h22, 1'b0}));
        tick();
        check("t1_b2_last", 32'({data_valid, data_byte, data_last}), 32'({1'b1, 8'h33, 1'b1}));
        tick();
        check("t1_end", 32'({data_valid, busy}), 32'h0);

        // Bad checksum, then a good one-byte packet.
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h04);
        check("t2_err_chk", 32'({err_chk, pkt_done, data_valid}), 32'h4);
        tick();
        check("t2_idle", 32'({err_chk, data_valid, busy}), 32'h0);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h55);
        send_byte(8'h54);
        check("t2_recover", 32'({pkt_done, data_valid, data_byte, data_last}), 32'({1'b1, 1'b1, 8'h55, 1'b1}));
        tick();
        check("t2_recover_end", 32'(data_valid), 32'h0);

        // Oversize length, then zero-length packet.
        send_byte(8'hA5);
        send_byte(8'h11);
        check("t3_err_len", 32'({err_len, busy}), 32'h2);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        check("t3_zero_len", 32'({pkt_done, data_valid, busy}), 32'h4);

        // Backpressure: hold 50 clocks, extra strobes in DRAIN, then toggling ready.
        data_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'hC3);
        send_byte(8'h3C);
        send_byte(8'hFD);
        check("t4_done", 32'({pkt_done, data_valid, data_byte}), 32'({1'b1, 1'b1, 8'hC3}));
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            rx_dv   = (i >= 10) && (i < 16);
            rx_byte = (i == 10) ? 8'hA5 : 8'h00;
            tick();
            if (!(data_valid === 1'b1 && data_byte === 8'hC3)) bad++;
        end
        rx_dv = 1'b0;
        check("t4_hold_stable", 32'(bad), 32'h0);
        rec_n = 0;
        for (int i = 0; i < 8; i++) begin
            data_ready = (i % 2) == 0;
            if (data_valid && data_ready && rec_n < 4) begin
                rec_byte[rec_n] = data_byte;
                rec_last[rec_n] = data_last;
                rec_n++;
            end
            tick();
        end
        data_ready = 1'b1;
        check("t4_count", 32'(rec_n), 32'd2);
        check("t4_first", 32'({rec_byte[0], rec_last[0]}), 32'({8'hC3, 1'b0}));
        check("t4_second", 32'({rec_byte[1], rec_last[1]}), 32'({8'h3C, 1'b1}));
        check("t4_end", 32'({data_valid, busy}), 32'h0);

        // Leading garbage is ignored.
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        check("t5_garbage_idle", 32'(busy), 32'h0);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h7E);
        send_byte(8'h7F);
        check("t5_single", 32'({pkt_done, data_valid, data_byte, data_last}), 32'({1'b1, 1'b1, 8'h7E, 1'b1}));
        tick();
        check("t5_end", 32'({data_valid, busy}), 32'h0);

`ifdef UART_PKT_TIMEOUT_EN
        // Silence after a partial payload expires 100 clocks after the last strobe.
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h10);
        to_at = -1;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (err_timeout === 1'b1) begin
                to_at = n;
                break;
            end
        end
        check("t6_timeout_at", 32'(to_at), 32'd100);
        check("t6_timeout_idle", 32'(busy), 32'h0);
        tick();
        check("t6_timeout_pulse", 32'(err_timeout), 32'h0);
`endif

        // Reset mid-payload aborts silently.
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        rst_n = 1'b0;
        tick();
        tick();
        check("t7_reset_outputs", 32'(outs()), 32'h0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (outs() !== 15'h0) bad++;
        end
        check("t7_no_pulses", 32'(bad), 32'h0);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h9A);
        send_byte(8'h9B);
        check("t7_after_reset", 32'({pkt_done, data_valid, data_byte}), 32'({1'b1, 1'b1, 8'h9A}));
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
